basic_control_unit: RTL and testbench

//  Hardwired control sequencer for the 16-bit accumulator datapath (AR, PC, DR, AC, IR, TR, E, INPR, OUTR).

---
 rtl/basic_control_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_basic_control_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_control_unit.sv
// Hardwired control sequencer for the 16-bit accumulator datapath.
// Latency: mem-ref 5-7 cycles, reg-ref/I/O 4 cycles, interrupt cycle 3 cycles.
// Backpressure: none; S=0 (HLT) freezes the sequencer until RST.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   ir                     IR contents: [15]=I, [14:12]=opcode, [11:0]=B11..B0
//   ac_zero, ac_sign       AC==0, AC[15]
//   dr_zero, e_in          DR==0, current E
//   fgi, fgo               input-ready / output-ready flags
//   bus_sel                bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
//   *_ld/*_inc/*_clr       register load/increment/clear strobes
//   mem_rd, mem_wr         memory read onto the bus / write M[AR] from the bus
//   alu_op                 AC source when ac_ld: 1 AND, 2 ADD, 3 DR, 4 CMA, 5 CIR, 6 CIL, 7 INPR
//   e_clr, e_cmp           clear / complement E
//   fgi_clr, fgo_clr       flag clears after INP / OUT
//   t_state, ien, halted   sequence counter, IEN flip-flop, S==0
module basic_control_unit #(
   parameter int wsize     = 16,
   parameter int addr      = 12,
   parameter int SCDECODER = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [wsize-1:0]     ir,
   input  logic                 ac_zero,
   input  logic                 ac_sign,
   input  logic                 dr_zero,
   input  logic                 e_in,
   input  logic                 fgi,
   input  logic                 fgo,
   output logic [2:0]           bus_sel,
   output logic                 ar_ld,
   output logic                 ar_inc,
   output logic                 ar_clr,
   output logic                 pc_ld,
   output logic                 pc_inc,
   output logic                 pc_clr,
   output logic                 dr_ld,
   output logic                 dr_inc,
   output logic                 ac_ld,
   output logic                 ac_inc,
   output logic                 ac_clr,
   output logic                 ir_ld,
   output logic                 tr_ld,
   output logic                 outr_ld,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [2:0]           alu_op,
   output logic                 e_clr,
   output logic                 e_cmp,
   output logic                 fgi_clr,
   output logic                 fgo_clr,
   output logic [SCDECODER-1:0] t_state,
   output logic                 ien,
   output logic                 halted
);

   typedef struct packed {
      logic [2:0] bus_sel;
      logic       ar_ld, ar_inc, ar_clr;
      logic       pc_ld, pc_inc, pc_clr;
      logic       dr_ld, dr_inc;
      logic       ac_ld, ac_inc, ac_clr;
      logic       ir_ld, tr_ld, outr_ld;
      logic       mem_rd, mem_wr;
      logic [2:0] alu_op;
      logic       e_clr, e_cmp;
      logic       fgi_clr, fgo_clr;
   } ctrl_t;

   // Bus sources (0 = bus idle, the default of a cleared ctrl_t)
   localparam logic [2:0] BUS_AR  = 3'd1;
   localparam logic [2:0] BUS_PC  = 3'd2;
   localparam logic [2:0] BUS_DR  = 3'd3;
   localparam logic [2:0] BUS_AC  = 3'd4;
   localparam logic [2:0] BUS_IR  = 3'd5;
   localparam logic [2:0] BUS_TR  = 3'd6;
   localparam logic [2:0] BUS_MEM = 3'd7;

   localparam logic [2:0] ALU_AND  = 3'd1;
   localparam logic [2:0] ALU_ADD  = 3'd2;
   localparam logic [2:0] ALU_DR   = 3'd3;
   localparam logic [2:0] ALU_CMA  = 3'd4;
   localparam logic [2:0] ALU_CIR  = 3'd5;
   localparam logic [2:0] ALU_CIL  = 3'd6;
   localparam logic [2:0] ALU_INPR = 3'd7;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_ISZ = 3'd6;
   localparam logic [2:0] OP_D7  = 3'd7;

   localparam logic [SCDECODER-1:0] T0 = SCDECODER'(0);
   localparam logic [SCDECODER-1:0] T1 = SCDECODER'(1);
   localparam logic [SCDECODER-1:0] T2 = SCDECODER'(2);
   localparam logic [SCDECODER-1:0] T3 = SCDECODER'(3);
   localparam logic [SCDECODER-1:0] T4 = SCDECODER'(4);
   localparam logic [SCDECODER-1:0] T5 = SCDECODER'(5);
   localparam logic [SCDECODER-1:0] T6 = SCDECODER'(6);

   logic [SCDECODER-1:0] sc_q, sc_d;
   logic                 r_q, r_d;
   logic                 ien_q, ien_d;
   logic                 s_q, s_d;
   logic                 i_q, i_d;

   logic [2:0]           d_op;
   logic [addr-1:0]      b;
   logic                 sc_clr;
   ctrl_t                ctl;
   ctrl_t                ctl_out;

   assign d_op = ir[wsize-2 -: 3];
   assign b    = ir[addr-1:0];

   always_comb begin
      ctl    = '0;
      sc_clr = 1'b0;
      r_d    = r_q;
      ien_d  = ien_q;
      s_d    = s_q;
      i_d    = i_q;

      if (sc_q <= T2) begin
         if (r_q) begin
            // Interrupt cycle: save PC at M[0], resume fetching from M[1]
            case (sc_q)
               T0: begin
                  ctl.ar_clr  = 1'b1;
                  ctl.bus_sel = BUS_PC;
                  ctl.tr_ld   = 1'b1;
               end
               T1: begin
                  ctl.bus_sel = BUS_TR;
                  ctl.mem_wr  = 1'b1;
                  ctl.pc_clr  = 1'b1;
               end
               default: begin
                  ctl.pc_inc = 1'b1;
                  ien_d      = 1'b0;
                  r_d        = 1'b0;
                  sc_clr     = 1'b1;
               end
            endcase
         end else begin
            case (sc_q)
               T0: begin
                  ctl.bus_sel = BUS_PC;
                  ctl.ar_ld   = 1'b1;
               end
               T1: begin
                  ctl.bus_sel = BUS_MEM;
                  ctl.mem_rd  = 1'b1;
                  ctl.ir_ld   = 1'b1;
                  ctl.pc_inc  = 1'b1;
               end
               default: begin
                  ctl.bus_sel = BUS_IR;
                  ctl.ar_ld   = 1'b1;
                  i_d         = ir[wsize-1];
               end
            endcase
         end
      end else if (sc_q == T3) begin
         if (d_op == OP_D7) begin
            sc_clr = 1'b1;
            if (!i_q) begin
               // Register-reference: one AC operation, one E operation
               if (b[11]) begin
                  ctl.ac_clr = 1'b1;
               end else if (b[9]) begin
                  ctl.ac_ld  = 1'b1;
                  ctl.alu_op = ALU_CMA;
               end else if (b[7]) begin
                  ctl.ac_ld  = 1'b1;
                  ctl.alu_op = ALU_CIR;
               end else if (b[6]) begin
                  ctl.ac_ld  = 1'b1;
                  ctl.alu_op = ALU_CIL;
               end else if (b[5]) begin
                  ctl.ac_inc = 1'b1;
               end
               if (b[10]) begin
                  ctl.e_clr = 1'b1;
               end else if (b[8]) begin
                  ctl.e_cmp = 1'b1;
               end
               // All skip tests fold into a single PC increment
               ctl.pc_inc = (b[4] & ~ac_sign) | (b[3] & ac_sign) |
                            (b[2] & ac_zero)  | (b[1] & ~e_in);
               if (b[0]) begin
                  s_d = 1'b0;
               end
            end else begin
               if (b[11]) begin
                  ctl.ac_ld   = 1'b1;
                  ctl.alu_op  = ALU_INPR;
                  ctl.fgi_clr = 1'b1;
               end
               if (b[10]) begin
                  ctl.bus_sel = BUS_AC;
                  ctl.outr_ld = 1'b1;
                  ctl.fgo_clr = 1'b1;
               end
               ctl.pc_inc = (b[9] & fgi) | (b[8] & fgo);
               if (b[7]) begin
                  ien_d = 1'b1;
               end
               // IOF after ION so it wins when both bits are set
               if (b[6]) begin
                  ien_d = 1'b0;
               end
            end
         end else if (i_q) begin
            // Indirect: AR <- M[AR]
            ctl.bus_sel = BUS_MEM;
            ctl.mem_rd  = 1'b1;
            ctl.ar_ld   = 1'b1;
         end
      end else begin
         case (d_op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
               case (sc_q)
                  T4: begin
                     ctl.bus_sel = BUS_MEM;
                     ctl.mem_rd  = 1'b1;
                     ctl.dr_ld   = 1'b1;
                  end
                  T5: begin
                     if (d_op == OP_ISZ) begin
                        ctl.dr_inc = 1'b1;
                     end else begin
                        ctl.ac_ld  = 1'b1;
                        ctl.alu_op = (d_op == OP_AND) ? ALU_AND :
                                     (d_op == OP_ADD) ? ALU_ADD : ALU_DR;
                        sc_clr     = 1'b1;
                     end
                  end
                  T6: begin
                     if (d_op == OP_ISZ) begin
                        ctl.bus_sel = BUS_DR;
                        ctl.mem_wr  = 1'b1;
                        ctl.pc_inc  = dr_zero;
                        sc_clr      = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            OP_STA: begin
               if (sc_q == T4) begin
                  ctl.bus_sel = BUS_AC;
                  ctl.mem_wr  = 1'b1;
                  sc_clr      = 1'b1;
               end
            end
            OP_BUN: begin
               if (sc_q == T4) begin
                  ctl.bus_sel = BUS_AR;
                  ctl.pc_ld   = 1'b1;
                  sc_clr      = 1'b1;
               end
            end
            OP_BSA: begin
               if (sc_q == T4) begin
                  ctl.bus_sel = BUS_PC;
                  ctl.mem_wr  = 1'b1;
                  ctl.ar_inc  = 1'b1;
               end else if (sc_q == T5) begin
                  ctl.bus_sel = BUS_AR;
                  ctl.pc_ld   = 1'b1;
                  sc_clr      = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Interrupts are only accepted outside fetch so IR/AR stay consistent
      if (!r_q && ien_q && (fgi || fgo) && (sc_q > T2)) begin
         r_d = 1'b1;
      end

      sc_d = sc_clr ? T0 : sc_q + SCDECODER'(1);

      if (!s_q) begin
         sc_d  = sc_q;
         r_d   = r_q;
         ien_d = ien_q;
         s_d   = s_q;
         i_d   = i_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sc_q  <= T0;
         r_q   <= 1'b0;
         ien_q <= 1'b0;
         s_q   <= 1'b1;
         i_q   <= 1'b0;
      end else begin
         sc_q  <= sc_d;
         r_q   <= r_d;
         ien_q <= ien_d;
         s_q   <= s_d;
         i_q   <= i_d;
      end
   end

   assign ctl_out = (RST || !s_q) ? '0 : ctl;

   assign bus_sel = ctl_out.bus_sel;
   assign ar_ld   = ctl_out.ar_ld;
   assign ar_inc  = ctl_out.ar_inc;
   assign ar_clr  = ctl_out.ar_clr;
   assign pc_ld   = ctl_out.pc_ld;
   assign pc_inc  = ctl_out.pc_inc;
   assign pc_clr  = ctl_out.pc_clr;
   assign dr_ld   = ctl_out.dr_ld;
   assign dr_inc  = ctl_out.dr_inc;
   assign ac_ld   = ctl_out.ac_ld;
   assign ac_inc  = ctl_out.ac_inc;
   assign ac_clr  = ctl_out.ac_clr;
   assign ir_ld   = ctl_out.ir_ld;
   assign tr_ld   = ctl_out.tr_ld;
   assign outr_ld = ctl_out.outr_ld;
   assign mem_rd  = ctl_out.mem_rd;
   assign mem_wr  = ctl_out.mem_wr;
   assign alu_op  = ctl_out.alu_op;
   assign e_clr   = ctl_out.e_clr;
   assign e_cmp   = ctl_out.e_cmp;
   assign fgi_clr = ctl_out.fgi_clr;
   assign fgo_clr = ctl_out.fgo_clr;

   assign t_state = sc_q;
   assign ien     = ien_q;
   assign halted  = ~s_q;

endmodule

// File: tb/tb_basic_control_unit.sv
// Testbench for basic_control_unit: per-instruction micro-op model plus literal spot checks.
module tb_basic_control_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] ir = 16'h0000;
   logic        ac_zero = 1'b0, ac_sign = 1'b0, dr_zero = 1'b0, e_in = 1'b0;
   logic        fgi = 1'b0, fgo = 1'b0;

   logic [2:0]  bus_sel, alu_op;
   logic        ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc;
   logic        ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, outr_ld, mem_rd, mem_wr;
   logic        e_clr, e_cmp, fgi_clr, fgo_clr, ien, halted;
   logic [3:0]  t_state;

   basic_control_unit dut (
      .CLK(CLK), .RST(RST), .ir(ir), .ac_zero(ac_zero), .ac_sign(ac_sign),
      .dr_zero(dr_zero), .e_in(e_in), .fgi(fgi), .fgo(fgo),
      .bus_sel(bus_sel), .ar_ld(ar_ld), .ar_inc(ar_inc), .ar_clr(ar_clr),
      .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_clr(pc_clr), .dr_ld(dr_ld), .dr_inc(dr_inc),
      .ac_ld(ac_ld), .ac_inc(ac_inc), .ac_clr(ac_clr), .ir_ld(ir_ld), .tr_ld(tr_ld),
      .outr_ld(outr_ld), .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op),
      .e_clr(e_clr), .e_cmp(e_cmp), .fgi_clr(fgi_clr), .fgo_clr(fgo_clr),
      .t_state(t_state), .ien(ien), .halted(halted)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0] bus;
      logic       ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc;
      logic       ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, outr_ld, mem_rd, mem_wr;
      logic [2:0] alu;
      logic       e_clr, e_cmp, fgi_clr, fgo_clr;
   } ctl_t;

   // One cycle of an instruction: its control word plus state effects at its end
   typedef struct packed {
      ctl_t c;
      logic ion, iof, hlt, rdone;
   } step_t;

   step_t q[$];
   int    m_t = 0;
   bit    m_r = 0, m_ien = 0, m_halt = 0, m_rst_seen = 0;
   int    checks = 0, errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Expand the instruction (or interrupt) about to start into its cycle sequence
   function automatic void build();
      step_t      s;
      logic [11:0] b;
      logic [2:0] d;
      logic       ind;
      bit         found;
      int         ac_bits[5] = '{11, 9, 7, 6, 5};
      b = ir[11:0];
      d = ir[14:12];
      ind = ir[15];
      if (m_r) begin
         s = '0; s.c.ar_clr = 1; s.c.bus = 3'd2; s.c.tr_ld = 1; q.push_back(s);
         s = '0; s.c.bus = 3'd6; s.c.mem_wr = 1; s.c.pc_clr = 1; q.push_back(s);
         s = '0; s.c.pc_inc = 1; s.iof = 1; s.rdone = 1; q.push_back(s);
         return;
      end
      s = '0; s.c.bus = 3'd2; s.c.ar_ld = 1; q.push_back(s);
      s = '0; s.c.bus = 3'd7; s.c.mem_rd = 1; s.c.ir_ld = 1; s.c.pc_inc = 1; q.push_back(s);
      s = '0; s.c.bus = 3'd5; s.c.ar_ld = 1; q.push_back(s);
      s = '0;
      if (d == 3'd7 && !ind) begin
         found = 0;
         for (int k = 0; k < 5; k++) begin
            if (!found && b[ac_bits[k]]) begin
               found = 1;
               case (k)
                  0: s.c.ac_clr = 1;
                  1: begin s.c.ac_ld = 1; s.c.alu = 3'd4; end
                  2: begin s.c.ac_ld = 1; s.c.alu = 3'd5; end
                  3: begin s.c.ac_ld = 1; s.c.alu = 3'd6; end
                  default: s.c.ac_inc = 1;
               endcase
            end
         end
         if (b[10]) s.c.e_clr = 1;
         else if (b[8]) s.c.e_cmp = 1;
         s.c.pc_inc = (b[4] && !ac_sign) || (b[3] && ac_sign) || (b[2] && ac_zero) || (b[1] && !e_in);
         s.hlt = b[0];
         q.push_back(s);
         return;
      end
      if (d == 3'd7) begin
         if (b[11]) begin s.c.ac_ld = 1; s.c.alu = 3'd7; s.c.fgi_clr = 1; end
         if (b[10]) begin s.c.bus = 3'd4; s.c.outr_ld = 1; s.c.fgo_clr = 1; end
         s.c.pc_inc = (b[9] && fgi) || (b[8] && fgo);
         s.ion = b[7];
         s.iof = b[6];
         q.push_back(s);
         return;
      end
      if (ind) begin s.c.bus = 3'd7; s.c.mem_rd = 1; s.c.ar_ld = 1; end
      q.push_back(s);
      case (d)
         3'd0, 3'd1, 3'd2: begin
            s = '0; s.c.bus = 3'd7; s.c.mem_rd = 1; s.c.dr_ld = 1; q.push_back(s);
            s = '0; s.c.ac_ld = 1; s.c.alu = d + 3'd1; q.push_back(s);
         end
         3'd3: begin s = '0; s.c.bus = 3'd4; s.c.mem_wr = 1; q.push_back(s); end
         3'd4: begin s = '0; s.c.bus = 3'd1; s.c.pc_ld = 1; q.push_back(s); end
         3'd5: begin
            s = '0; s.c.bus = 3'd2; s.c.mem_wr = 1; s.c.ar_inc = 1; q.push_back(s);
            s = '0; s.c.bus = 3'd1; s.c.pc_ld = 1; q.push_back(s);
         end
         default: begin
            s = '0; s.c.bus = 3'd7; s.c.mem_rd = 1; s.c.dr_ld = 1; q.push_back(s);
            s = '0; s.c.dr_inc = 1; q.push_back(s);
            s = '0; s.c.bus = 3'd3; s.c.mem_wr = 1; s.c.pc_inc = dr_zero; q.push_back(s);
         end
      endcase
   endfunction

   // Compare process: every cycle, mid-cycle, then advance the model across the edge
   initial begin
      step_t s;
      ctl_t  dc;
      bit    elig;
      forever begin
         @(negedge CLK);
         dc = {bus_sel, ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc,
               ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, outr_ld, mem_rd, mem_wr,
               alu_op, e_clr, e_cmp, fgi_clr, fgo_clr};
         if (RST) begin
            chk("ctl_in_reset", 32'(dc), 0);
            if (m_rst_seen) begin
               chk("t_state_in_reset", 32'(t_state), 0);
               chk("ien_in_reset", 32'(ien), 0);
               chk("halted_in_reset", 32'(halted), 0);
            end
            q.delete();
            m_t = 0; m_r = 0; m_ien = 0; m_halt = 0; m_rst_seen = 1;
         end else if (m_halt) begin
            m_rst_seen = 0;
            chk("ctl_halted", 32'(dc), 0);
            chk("t_state_halted", 32'(t_state), 32'(m_t));
            chk("halted_flag", 32'(halted), 1);
            chk("ien_halted", 32'(ien), 32'(m_ien));
         end else begin
            m_rst_seen = 0;
            if (q.size() == 0) build();
            s = q.pop_front();
            chk("ctl_word", 32'(dc), 32'(s.c));
            chk("t_state", 32'(t_state), 32'(m_t));
            chk("ien", 32'(ien), 32'(m_ien));
            chk("halted", 32'(halted), 0);
            elig = (m_t >= 3) && !m_r && m_ien && (fgi || fgo);
            if (s.ion) m_ien = 1;
            if (s.iof) m_ien = 0;
            if (s.hlt) m_halt = 1;
            if (s.rdone) m_r = 0;
            if (elig) m_r = 1;
            m_t = (q.size() == 0) ? 0 : m_t + 1;
         end
      end
   end

   task automatic go(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic instr(input logic [15:0] v, input int n);
      ir = v;
      go(n);
   endtask

   initial begin
      ir = 16'h7800;
      go(1); #2;
      chk("rst_bus_sel", 32'(bus_sel), 0);
      chk("rst_ar_ld", 32'(ar_ld), 0);
      chk("rst_t_state", 32'(t_state), 0);
      chk("rst_ien", 32'(ien), 0);
      chk("rst_halted", 32'(halted), 0);
      go(2);

      // LDA direct
      RST = 0; ir = 16'h2105; #2;
      chk("t0_bus_pc", 32'(bus_sel), 2);
      chk("t0_ar_ld", 32'(ar_ld), 1);
      chk("t0_t_state", 32'(t_state), 0);
      go(4); #2;
      chk("lda_t4_dr_ld", 32'(dr_ld), 1);
      chk("lda_t4_mem_rd", 32'(mem_rd), 1);
      chk("lda_t4_t_state", 32'(t_state), 4);
      go(1); #2;
      chk("lda_t5_ac_ld", 32'(ac_ld), 1);
      chk("lda_t5_alu", 32'(alu_op), 3);
      go(1);

      // ADD indirect
      ir = 16'h9200; #2;
      chk("lda_done_t_state", 32'(t_state), 0);
      go(3); #2;
      chk("add_t3_bus_mem", 32'(bus_sel), 7);
      chk("add_t3_ar_ld", 32'(ar_ld), 1);
      go(2); #2;
      chk("add_t5_ac_ld", 32'(ac_ld), 1);
      chk("add_t5_alu", 32'(alu_op), 2);
      go(1);

      // ISZ, skip taken then not taken
      ir = 16'h6010; dr_zero = 1;
      go(6); #2;
      chk("isz_z_mem_wr", 32'(mem_wr), 1);
      chk("isz_z_pc_inc", 32'(pc_inc), 1);
      go(1);
      dr_zero = 0;
      go(6); #2;
      chk("isz_nz_mem_wr", 32'(mem_wr), 1);
      chk("isz_nz_pc_inc", 32'(pc_inc), 0);
      chk("isz_nz_t_state", 32'(t_state), 6);
      go(1);

      // STA, BUN, BSA, AND
      instr(16'h3005, 5);
      instr(16'h4005, 5);
      instr(16'h5005, 6);
      instr(16'h0005, 6);

      // Register-reference combinations
      ir = 16'h7A00; go(3); #2;
      chk("cla_over_cma_clr", 32'(ac_clr), 1);
      chk("cla_over_cma_ld", 32'(ac_ld), 0);
      go(1);
      ir = 16'h7290; go(3); #2;
      chk("cma_over_cir_alu", 32'(alu_op), 4);
      chk("spa_pc_inc", 32'(pc_inc), 1);
      go(1);
      ir = 16'h7500; go(3); #2;
      chk("cle_over_cme_clr", 32'(e_clr), 1);
      chk("cle_over_cme_cmp", 32'(e_cmp), 0);
      go(1);
      ir = 16'h700C; ac_zero = 1; go(3); #2;
      chk("sna_sza_or", 32'(pc_inc), 1);
      go(1);
      ac_zero = 0; ir = 16'h7002; e_in = 1; go(3); #2;
      chk("sze_no_skip", 32'(pc_inc), 0);
      go(1);
      e_in = 0; ir = 16'h7060; go(3); #2;
      chk("cil_over_inc_alu", 32'(alu_op), 6);
      chk("cil_over_inc_inc", 32'(ac_inc), 0);
      go(1);

      // I/O instructions
      ir = 16'hF800; go(3); #2;
      chk("inp_alu", 32'(alu_op), 7);
      chk("inp_fgi_clr", 32'(fgi_clr), 1);
      go(1);
      ir = 16'hF400; go(3); #2;
      chk("out_bus_ac", 32'(bus_sel), 4);
      chk("out_outr_ld", 32'(outr_ld), 1);
      go(1);
      ir = 16'hF200; fgi = 1; go(3); #2;
      chk("ski_pc_inc", 32'(pc_inc), 1);
      go(1);
      fgi = 0; ir = 16'hF0C0; go(4); #2;
      chk("iof_wins_ien", 32'(ien), 0);

      // Interrupt raised during T4 of LDA
      ir = 16'hF080; go(4); #2;
      chk("ion_ien", 32'(ien), 1);
      ir = 16'h2105; go(4);
      fgi = 1; go(2); #2;
      chk("rt0_ar_clr", 32'(ar_clr), 1);
      chk("rt0_tr_ld", 32'(tr_ld), 1);
      chk("rt0_bus_pc", 32'(bus_sel), 2);
      fgi = 0; go(1); #2;
      chk("rt1_mem_wr", 32'(mem_wr), 1);
      chk("rt1_pc_clr", 32'(pc_clr), 1);
      go(1); #2;
      chk("rt2_pc_inc", 32'(pc_inc), 1);
      chk("rt2_t_state", 32'(t_state), 2);
      go(1); #2;
      chk("after_int_ien", 32'(ien), 0);
      chk("after_int_fetch", 32'(ar_ld), 1);

      // Interrupt set on the same edge as STA's SC clear
      ir = 16'hF080; go(4);
      ir = 16'h3005; go(4);
      fgi = 1; go(1); #2;
      chk("same_edge_rt0_tr_ld", 32'(tr_ld), 1);
      chk("same_edge_rt0_t_state", 32'(t_state), 0);
      fgi = 0; go(3);

      // Halt with interrupts enabled, then restart by reset
      ir = 16'hF080; go(4);
      ir = 16'h7001; go(3); #2;
      chk("hlt_t3_not_halted", 32'(halted), 0);
      go(1); #2;
      chk("hlt_halted", 32'(halted), 1);
      chk("hlt_bus_idle", 32'(bus_sel), 0);
      fgi = 1; go(5); #2;
      chk("hlt_frozen_t_state", 32'(t_state), 0);
      chk("hlt_ignores_int", 32'(tr_ld), 0);
      chk("hlt_ien_frozen", 32'(ien), 1);
      RST = 1; go(1);
      RST = 0; fgi = 0; ir = 16'h2105; #2;
      chk("restart_halted", 32'(halted), 0);
      chk("restart_t_state", 32'(t_state), 0);
      chk("restart_bus_pc", 32'(bus_sel), 2);

      // Reset in the middle of an instruction
      go(4);
      RST = 1; go(2);
      RST = 0; #2;
      chk("midrst_t_state", 32'(t_state), 0);
      chk("midrst_ar_ld", 32'(ar_ld), 1);
      go(6);
      go(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
